dmem_access_ctrl: RTL and testbench

Sequencing controller and two-way arbiter in front of the single-ported, 32-bit-word data memory. It serves two requesters: port A is the pipeline MEM stage and port B is the debug/program loader. Each 64-bit access is split into two 32-bit word beats: the high word goes to byte address `addr`, the low word to `addr+4`. The block also enforces alignment and write protection of the reserved/instruction region below the data base.

---
 rtl/dmem_access_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Round-robin arbiter and beat sequencer between the MEM stage (A), the debug loader (B)
// and the single-ported 32-bit data memory. Each 64-bit access is split into two beats:
// the high word goes to addr and the low word goes to addr+4.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_BASE = 32'h1800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [63:0]       a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [63:0]       b_wdata,
  output logic              a_done,
  output logic              a_err,
  output logic [63:0]       a_rdata,
  output logic              b_done,
  output logic              b_err,
  output logic [63:0]       b_rdata,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned WORD_W   = ADDR_W - 2;
  localparam int unsigned TOP_ADDR = (32'd1 << ADDR_W) - 32'd8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_CAP   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q;
  logic                gnt_b_q;
  logic                last_b_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [63:0]         wdata_q;
  logic [31:0]         rd_hi_q;

  logic                a_done_q;
  logic                a_err_q;
  logic [63:0]         a_rdata_q;
  logic                b_done_q;
  logic                b_err_q;
  logic [63:0]         b_rdata_q;
  logic [WORD_W-1:0]   mem_addr_q;
  logic                mem_we_q;
  logic                mem_re_q;
  logic [31:0]         mem_wdata_q;

  logic                sel_any;
  logic                sel_b;
  logic                sel_we;
  logic                sel_err;
  logic [ADDR_W-1:0]   sel_addr;
  logic [63:0]         sel_wdata;
  logic [WORD_W-1:0]   beat1_addr;

  // Grant choice and access checks; only consumed on the IDLE edge.
  always_comb begin
    sel_any   = a_req | b_req;
    sel_b     = b_req & (~a_req | ~last_b_q);
    sel_we    = sel_b ? b_we    : a_we;
    sel_addr  = sel_b ? b_addr  : a_addr;
    sel_wdata = sel_b ? b_wdata : a_wdata;
    sel_err   = (sel_addr[2:0] != 3'd0)
              | (sel_we & (32'(sel_addr) < DATA_BASE))
              | (32'(sel_addr) > TOP_ADDR);
  end

  assign beat1_addr = addr_q[ADDR_W-1:2] + WORD_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_b_q     <= 1'b0;
      last_b_q    <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_hi_q     <= '0;
      a_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_done_q    <= 1'b0;
      b_err_q     <= 1'b0;
      b_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      a_done_q <= 1'b0;
      a_err_q  <= 1'b0;
      b_done_q <= 1'b0;
      b_err_q  <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (sel_any) begin
            gnt_b_q <= sel_b;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            if (sel_err) begin
              // Rejected accesses skip the memory entirely.
              state_q  <= S_DONE;
              a_done_q <= ~sel_b;
              a_err_q  <= ~sel_b;
              b_done_q <= sel_b;
              b_err_q  <= sel_b;
            end else begin
              state_q    <= S_BEAT0;
              mem_addr_q <= sel_addr[ADDR_W-1:2];
              mem_we_q   <= sel_we;
              mem_re_q   <= ~sel_we;
              if (sel_we) mem_wdata_q <= sel_wdata[63:32];
            end
          end
        end
        S_BEAT0: begin
          state_q    <= S_BEAT1;
          mem_addr_q <= beat1_addr;
          mem_we_q   <= we_q;
          mem_re_q   <= ~we_q;
          if (we_q) mem_wdata_q <= wdata_q[31:0];
        end
        S_BEAT1: begin
          if (we_q) begin
            state_q  <= S_DONE;
            a_done_q <= ~gnt_b_q;
            b_done_q <= gnt_b_q;
          end else begin
            // High word read in BEAT0 arrives now.
            state_q <= S_CAP;
            rd_hi_q <= mem_rdata;
          end
        end
        S_CAP: begin
          state_q <= S_DONE;
          if (gnt_b_q) begin
            b_done_q  <= 1'b1;
            b_rdata_q <= {rd_hi_q, mem_rdata};
          end else begin
            a_done_q  <= 1'b1;
            a_rdata_q <= {rd_hi_q, mem_rdata};
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          last_b_q <= gnt_b_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_done    = a_done_q;
  assign a_err     = a_err_q;
  assign a_rdata   = a_rdata_q;
  assign b_done    = b_done_q;
  assign b_err     = b_err_q;
  assign b_rdata   = b_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed scenarios plus random two-port
// traffic against a 64-bit-granular reference memory and round-robin model.
module tb_dmem_access_ctrl;

  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned DATA_BASE = 32'h1800;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [63:0]       a_wdata = '0, b_wdata = '0;
  logic              a_done, a_err, b_done, b_err;
  logic [63:0]       a_rdata, b_rdata;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_we, mem_re;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_BASE(DATA_BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Physical word memory with one-cycle read latency.
  logic [31:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: memory held as 64-bit values, round-robin as a single bit.
  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          done_cyc;
    int          n_we;
    int          n_re;
  } exp_t;

  exp_t        a_q[$];
  exp_t        b_q[$];
  logic [63:0] ref_mem [int];
  logic [63:0] m_rd [2];
  bit          m_last_b = 1'b1;

  function automatic int service(input bit pb, input bit we, input int addr,
                                 input logic [63:0] wd, input int start, output exp_t e);
    bit err;
    int lat;
    err = (addr % 8 != 0) || (we && addr < int'(DATA_BASE)) || (addr > 16384 - 8);
    lat = err ? 1 : (we ? 3 : 4);
    if (!err && we) ref_mem[addr / 8] = wd;
    if (!err && !we) m_rd[pb] = ref_mem.exists(addr / 8) ? ref_mem[addr / 8] : 64'd0;
    e.err      = err;
    e.rdata    = m_rd[pb];
    e.done_cyc = start + lat;
    e.n_we     = (!err && we) ? 2 : 0;
    e.n_re     = (!err && !we) ? 2 : 0;
    m_last_b   = pb;
    return lat;
  endfunction

  typedef struct {
    int          c;
    bit          we;
    bit          re;
    logic [11:0] addr;
    logic [31:0] wd;
  } strobe_t;
  strobe_t strobe_log[$];

  // Monitor: counts strobes per access and checks every completion it sees.
  int          n_we = 0, n_re = 0;
  logic [63:0] sh_a = '0, sh_b = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n_we = 0; n_re = 0; sh_a = '0; sh_b = '0;
    end else begin
      if (mem_we) n_we++;
      if (mem_re) n_re++;
      if (mem_we || mem_re) strobe_log.push_back('{cyc, mem_we, mem_re, mem_addr, mem_wdata});
      if (a_done && b_done) chk("both_done", 64'd1, 64'd0);
      if (!a_done && a_err) chk("a_err_no_done", 64'(a_err), 64'd0);
      if (!b_done && b_err) chk("b_err_no_done", 64'(b_err), 64'd0);
      if (a_done) begin
        if (a_q.size() == 0) chk("a_done_unexpected", 64'd1, 64'd0);
        else begin
          e = a_q.pop_front();
          chk("a_err", 64'(a_err), 64'(e.err));
          chk("a_rdata", a_rdata, e.rdata);
          chk("a_done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("a_mem_we_beats", 64'(n_we), 64'(e.n_we));
          chk("a_mem_re_beats", 64'(n_re), 64'(e.n_re));
          chk("b_rdata_isolated", b_rdata, sh_b);
          sh_a = e.rdata;
        end
        n_we = 0; n_re = 0;
      end
      if (b_done) begin
        if (b_q.size() == 0) chk("b_done_unexpected", 64'd1, 64'd0);
        else begin
          e = b_q.pop_front();
          chk("b_err", 64'(b_err), 64'(e.err));
          chk("b_rdata", b_rdata, e.rdata);
          chk("b_done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("b_mem_we_beats", 64'(n_we), 64'(e.n_we));
          chk("b_mem_re_beats", 64'(n_re), 64'(e.n_re));
          chk("a_rdata_isolated", a_rdata, sh_a);
          sh_b = e.rdata;
        end
        n_we = 0; n_re = 0;
      end
    end
  end

  // Issue one access on A and/or B from IDLE, predict, then hold req until done.
  task automatic run(input bit do_a, input bit awe, input int aad, input logic [63:0] awd,
                     input bit do_b, input bit bwe, input int bad_, input logic [63:0] bwd);
    exp_t e;
    int   start, lat;
    bit   pa, pb, da, db;
    start   = cyc;
    a_req   = do_a;  a_we = awe;  a_addr = ADDR_W'(aad);  a_wdata = awd;
    b_req   = do_b;  b_we = bwe;  b_addr = ADDR_W'(bad_); b_wdata = bwd;
    if (do_a && do_b) begin
      if (m_last_b) begin
        lat = service(1'b0, awe, aad, awd, start, e);           a_q.push_back(e);
        lat = service(1'b1, bwe, bad_, bwd, start + lat + 1, e); b_q.push_back(e);
      end else begin
        lat = service(1'b1, bwe, bad_, bwd, start, e);          b_q.push_back(e);
        lat = service(1'b0, awe, aad, awd, start + lat + 1, e);  a_q.push_back(e);
      end
    end else if (do_a) begin
      lat = service(1'b0, awe, aad, awd, start, e); a_q.push_back(e);
    end else if (do_b) begin
      lat = service(1'b1, bwe, bad_, bwd, start, e); b_q.push_back(e);
    end
    pa = do_a; pb = do_b;
    for (int c = 0; c < 24 && (pa || pb); c++) begin
      @(negedge clk);
      da = a_done; db = b_done;
      @(posedge clk); #1;
      if (da && pa) begin pa = 1'b0; a_req = 1'b0; a_addr = ADDR_W'($urandom); a_we = 1'($urandom); end
      if (db && pb) begin pb = 1'b0; b_req = 1'b0; b_addr = ADDR_W'($urandom); b_we = 1'($urandom); end
    end
    if (pa || pb) begin
      chk("done_timeout", {62'd0, pa, pb}, 64'd0);
      a_req = 1'b0; b_req = 1'b0;
      a_q.delete(); b_q.delete();
    end
  endtask

  function automatic int rand_addr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 11) return 32'h3FF8;
    if (r == 12) return 8 * int'($urandom_range(0, 31)) + 32'h100;
    if (r == 13) return int'(DATA_BASE) + 8 * int'($urandom_range(0, 11)) + int'($urandom_range(1, 7));
    return int'(DATA_BASE) + 8 * int'($urandom_range(0, 11));
  endfunction

  initial begin
    int st;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_done", 64'(a_done), 64'd0);
    chk("rst_b_done", 64'(b_done), 64'd0);
    chk("rst_errs", {62'd0, a_err, b_err}, 64'd0);
    chk("rst_strobes", {62'd0, mem_we, mem_re}, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_a_rdata", a_rdata, 64'd0);
    chk("rst_b_rdata", b_rdata, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Simultaneous stores out of reset: A first, then B first on the repeat.
    run(1, 1, 32'h1820, 64'hA0A0_0001_A0A0_0002, 1, 1, 32'h1828, 64'hB0B0_0003_B0B0_0004);
    run(1, 1, 32'h1830, 64'hA1A1_0005_A1A1_0006, 1, 1, 32'h1838, 64'hB1B1_0007_B1B1_0008);
    run(1, 0, 32'h1828, 64'd0, 1, 0, 32'h1820, 64'd0);

    // Store then load on A with beat-level strobe checks.
    strobe_log.delete();
    st = cyc;
    run(1, 1, 32'h1800, 64'h1111_2222_3333_4444, 0, 0, 0, 64'd0);
    chk("st_beats", 64'(strobe_log.size()), 64'd2);
    if (strobe_log.size() == 2) begin
      chk("st_beat0_cycle", 64'(strobe_log[0].c), 64'(st + 1));
      chk("st_beat0", {strobe_log[0].we, strobe_log[0].re, 18'd0, strobe_log[0].addr, strobe_log[0].wd},
          {1'b1, 1'b0, 18'd0, 12'h600, 32'h1111_2222});
      chk("st_beat1_cycle", 64'(strobe_log[1].c), 64'(st + 2));
      chk("st_beat1", {strobe_log[1].we, strobe_log[1].re, 18'd0, strobe_log[1].addr, strobe_log[1].wd},
          {1'b1, 1'b0, 18'd0, 12'h601, 32'h3333_4444});
    end
    run(1, 0, 32'h1800, 64'd0, 0, 0, 0, 64'd0);

    // Misaligned B load: immediate error, no memory traffic.
    strobe_log.delete();
    run(0, 0, 0, 64'd0, 1, 0, 32'h1804, 64'd0);
    chk("misaligned_no_strobe", 64'(strobe_log.size()), 64'd0);

    // Write protection below the data base; loads there are fine.
    run(1, 1, 32'h0100, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0, 64'd0);
    run(1, 0, 32'h0100, 64'd0, 0, 0, 0, 64'd0);

    // Isolation and top-of-memory bounds.
    run(0, 0, 0, 64'd0, 1, 0, 32'h1808, 64'd0);
    run(1, 1, 32'h3FF8, 64'h5555_6666_7777_8888, 0, 0, 0, 64'd0);
    chk("top_hi_word", 64'(mem[12'hFFE]), 64'h5555_6666);
    chk("top_lo_word", 64'(mem[12'hFFF]), 64'h7777_8888);
    run(0, 0, 0, 64'd0, 1, 0, 32'h3FF8, 64'd0);

    // Reset during BEAT1 of a store: no done, high word committed.
    a_req = 1'b1; a_we = 1'b1; a_addr = 14'h1810; a_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; a_req = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_done", {62'd0, a_done, b_done}, 64'd0);
    chk("rstmid_strobes", {62'd0, mem_we, mem_re}, 64'd0);
    chk("rstmid_mem_addr", 64'(mem_addr), 64'd0);
    chk("rstmid_rdata", a_rdata | b_rdata, 64'd0);
    m_rd[0] = '0; m_rd[1] = '0; m_last_b = 1'b1;
    chk("rstmid_hi_word", 64'(mem[12'h604]), 64'hAAAA_BBBB);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    run(1, 1, 32'h1810, 64'h0102_0304_0506_0708, 0, 0, 0, 64'd0);

    // Random two-port traffic.
    for (int i = 0; i < 80; i++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      run(mode != 1, 1'($urandom), rand_addr(), {$urandom, $urandom},
          mode != 0, 1'($urandom), rand_addr(), {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    chk("queues_drained", 64'(a_q.size() + b_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
